// File: rtl/mem_rsp.sv
// Main-memory response path: one bus transaction per processor request, with NXM timeout.
// Optional MEM_PARITY_EN adds bus/MD parity generation and checking.
module mem_rsp #(
  parameter int ADDR_W  = 22,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memrq,
  input  logic              wrcyc,
  input  logic [ADDR_W-1:0] vma,
  input  logic [31:0]       md_in,
  input  logic              nxm_clr,
  output logic [31:0]       mds,
  output logic              loadmd,
  output logic              memack,
  output logic              memstall,
  output logic              nxm,
  output logic              bus_req,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
`ifdef MEM_PARITY_EN
  ,
  output logic              bus_wpar,
  input  logic              bus_rpar,
  output logic              mdhaspar,
  output logic              mdpar,
  output logic              parerr
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          expire;
  logic          accept;
  logic          ack_ok;
  logic          tmo;

  assign expire = (cnt == CW'(TIMEOUT - 1));
  assign accept = (state == IDLE) && memrq;
  assign ack_ok = (state == REQ) && bus_ack;
  assign tmo    = (state == REQ) && !bus_ack && expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus_req   = 1'b0;
    memack    = 1'b0;
    loadmd    = 1'b0;
    memstall  = 1'b0;
    unique case (state)
      IDLE: begin
        if (memrq) state_nxt = REQ;
      end
      REQ: begin
        bus_req  = 1'b1;
        memstall = 1'b1;
        if (bus_ack || expire) state_nxt = DONE;
      end
      DONE: begin
        memack    = 1'b1;
        loadmd    = !bus_write;
        memstall  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_addr  <= '0;
      bus_write <= 1'b0;
      bus_wdata <= '0;
      cnt       <= '0;
    end else if (accept) begin
      bus_addr  <= vma;
      bus_write <= wrcyc;
      bus_wdata <= md_in;
      cnt       <= '0;
    end else if (state == REQ && !bus_ack && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Timeout set takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         nxm <= 1'b0;
    else if (tmo)      nxm <= 1'b1;
    else if (nxm_clr)  nxm <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   mds <= '0;
    else if (ack_ok && !bus_write) mds <= bus_rdata;
    else if (tmo && !bus_write)    mds <= 32'hFFFF_FFFF;
  end

`ifdef MEM_PARITY_EN
  logic rd_bad;
  assign rd_bad = ack_ok && !bus_write && ((^bus_rdata) != bus_rpar);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_wpar <= 1'b0;
      mdhaspar <= 1'b0;
      mdpar    <= 1'b0;
    end else begin
      if (accept) bus_wpar <= ^md_in;
      if (ack_ok && !bus_write) begin
        mdhaspar <= 1'b1;
        mdpar    <= bus_rpar;
      end else if (tmo && !bus_write) begin
        mdhaspar <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        parerr <= 1'b0;
    else if (rd_bad)  parerr <= 1'b1;
    else if (nxm_clr) parerr <= 1'b0;
  end
`endif

endmodule

// File: doc/mem_rsp.md
Name: mem_rsp

Overview:
Main-memory side of the CADR memory data path. Accepts a processor memory request (address from VMA, write data from MD), runs one transaction on the external memory bus and, for reads, returns data on mds with a one-cycle loadmd strobe that loads MD. Covers bus timeout as nonexistent memory (NXM) and busy/stall reporting to the sequencer.

Parameters:
ADDR_W, 22, width of the physical word address (vma/bus_addr).
TIMEOUT, 255, cycles bus_req may stay unacknowledged before NXM; legal range 1..1023.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
memrq  in  1  memory request level from sequencer; sampled only in IDLE
wrcyc  in  1  1 = write, 0 = read; sampled with memrq
vma  in  ADDR_W  request address
md_in  in  32  write data (MD contents)
nxm_clr  in  1  clears sticky nxm flag
mds  out  32  read data to MD
loadmd  out  1  one-cycle strobe: mds valid, load MD
memack  out  1  one-cycle strobe: transaction finished (read or write)
memstall  out  1  1 while a transaction is in flight
nxm  out  1  sticky nonexistent-memory flag
bus_req  out  1  external bus request
bus_write  out  1  external bus direction
bus_addr  out  ADDR_W  external bus address
bus_wdata  out  32  external bus write data
bus_rdata  in  32  external bus read data, valid with bus_ack
bus_ack  in  1  external bus acknowledge, single cycle

Behaviour:
- Reset (async, immediate): state IDLE; mds=0, loadmd=0, memack=0, memstall=0, nxm=0, bus_req=0, bus_write=0, bus_addr=0, bus_wdata=0, timeout counter=0. Reset mid-transaction drops bus_req at once; late bus_ack after reset is ignored.
- States: IDLE, REQ, DONE.
- IDLE: memrq=1 at edge -> latch vma, wrcyc, md_in into bus_addr/bus_write/bus_wdata; bus_req=1, memstall=1, counter=0; go REQ. memrq=0 -> stay.
- REQ: bus_req held, bus_addr/bus_write/bus_wdata stable. bus_ack=1 -> bus_req=0; if read, mds<=bus_rdata; go DONE. Else counter+1; when counter reaches TIMEOUT-1 with no ack (TIMEOUT cycles of bus_req) -> bus_req=0, nxm<=1, read data mds<=32'hFFFFFFFF; go DONE.
- DONE (one cycle): memack=1; loadmd=1 only if read; memstall=0 from next edge; go IDLE. Next request accepted earliest the cycle after DONE (min 3 cycles per transaction, ack in first REQ cycle).
- Read latency: memrq accept edge -> loadmd high exactly 1 cycle after the bus_ack cycle.
- Writes: mds unchanged, loadmd stays 0.
- memrq asserted in REQ/DONE: ignored; requester holds memrq until memack.
- bus_ack outside REQ: ignored.
- nxm sticky until nxm_clr; nxm_clr and new timeout same cycle -> nxm=1 (set wins).
- Counter width ceil(log2(TIMEOUT+1)); never wraps (stops in DONE).

Optional Feature:
MEM_PARITY_EN defined: adds output bus_wpar (odd parity of bus_wdata, registered with it), input bus_rpar, outputs mdhaspar and mdpar. On read bus_ack, mdhaspar<=1, mdpar<=bus_rpar; parity mismatch (odd parity of bus_rdata != bus_rpar) sets sticky parerr output, cleared by nxm_clr. NXM read: mdhaspar<=0. Reset clears all. Undefined: none of these ports exist; behaviour otherwise identical.

Test Plan:
Read: memrq=1, wrcyc=0, vma=22'h001234, bus_ack 2 cycles after bus_req with bus_rdata=32'hDEADBEEF -> bus_addr=22'h001234, bus_write=0, loadmd one cycle after ack, mds=32'hDEADBEEF, memack same cycle, memstall low next.
Write: wrcyc=1, md_in=32'h12345678, vma=22'h3FFFFF, ack after 1 cycle -> bus_write=1, bus_wdata=32'h12345678, memack pulse, loadmd never high, mds unchanged.
Timeout: TIMEOUT=4, read, no bus_ack -> bus_req high exactly 4 cycles, nxm=1, mds=32'hFFFFFFFF, loadmd pulse; nxm_clr -> nxm=0.
Busy/back-to-back: memrq held high across two reads, second vma changed during REQ -> second transaction uses vma sampled in IDLE after DONE; no request lost or duplicated.
Reset mid-op: assert reset during REQ -> bus_req=0 immediately; subsequent bus_ack produces no loadmd/memack.
Parity (MEM_PARITY_EN): read with bus_rdata=32'h00000001, bus_rpar=0 -> parerr=1, mdhaspar=1, mdpar=0.
